// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync pulses, active flag, pixel coordinates and strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if ((H_TOTAL - 1) >= (1 << CNT_W)) begin : g_h_width_chk
      $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if ((V_TOTAL - 1) >= (1 << CNT_W)) begin : g_v_width_chk
      $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic             HS_ON      = (H_SYNC_POL != 0);
  localparam logic             VS_ON      = (V_SYNC_POL != 0);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;
  logic             h_sync_zone;
  logic             v_sync_zone;
  logic             vis;
  logic             h_zero;
  logic             v_zero;

  // Decodes use the pre-increment counters; outputs register them one cycle later.
  always_comb begin
    h_last      = (h_cnt == H_LAST);
    v_last      = (v_cnt == V_LAST);
    h_sync_zone = (h_cnt >= HS_START) && (h_cnt < HS_END);
    v_sync_zone = (v_cnt >= VS_START) && (v_cnt < VS_END);
    vis         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    h_zero      = (h_cnt == CNT_ZERO);
    v_zero      = (v_cnt == CNT_ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      hsync       <= !HS_ON;
      vsync       <= !VS_ON;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? CNT_ZERO : v_cnt + CNT_ONE;
        end else begin
          h_cnt <= h_cnt + CNT_ONE;
        end
        x           <= h_cnt;
        y           <= v_cnt;
        hsync       <= h_sync_zone ? HS_ON : !HS_ON;
        vsync       <= v_sync_zone ? VS_ON : !VS_ON;
        active      <= vis;
        line_start  <= h_zero;
        frame_start <= h_zero && v_zero;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Bumped on the same edge that raises frame_start, so pixel (0,0) carries the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (en && h_zero && v_zero) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator: horizontal and vertical counters, sync pulses, active-video flag, pixel coordinates and frame/line strobes.
- Successor to the horizontal-only sync counter. Adds a vertical axis, programmable timings and polarity, a pixel-enable input for clock division, and an async reset.
- Sits between the pixel clock domain and the framebuffer/pixel pipeline of the monitor tester.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 10, counter / coordinate width

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  pixel tick; counters advance only when high
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- active  out  1  high when both x and y are in the visible region
- x  out  CNT_W  horizontal counter value
- y  out  CNT_W  vertical counter value
- line_start  out  1  one-cycle strobe at h_cnt==0
- frame_start  out  1  one-cycle strobe at h_cnt==0 and v_cnt==0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Line/frame order: active, front porch, sync, back porch.
  - hsync asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync asserted for 490 <= v_cnt < 492.
- Elaboration check: if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W, report an error via a generate-time $error.
- Reset (async, asserted):
  - h_cnt=0, v_cnt=0, x=0, y=0, active=0, line_start=0, frame_start=0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL (deasserted).
  - Takes effect immediately, mid-line or mid-frame; no partial pulse is completed.
  - First en cycle after release restarts at (0,0).
- Counter advance, on posedge clk with en=1:
  - If h_cnt == H_TOTAL-1: h_cnt <= 0, and v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1.
  - Otherwise h_cnt <= h_cnt+1 and v_cnt holds.
- Output registers (all registered, 1-cycle latency):
  - On each en cycle, every output is computed from the pre-increment counter values sampled at that edge.
  - So x/y equal the counter value of the previous en cycle.
  - hsync, vsync and active are aligned with x/y in the same cycle.
- en=0: counters and x, y, hsync, vsync, active hold; line_start and frame_start forced 0.
  - Each strobe is high for exactly one clk cycle per qualifying en tick.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- vsync edges coincide with the output cycle where x == 0 (line boundary).
- Wrap: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0); frame_start fires once per frame.
  - One frame = H_TOTAL*V_TOTAL en ticks (420000).
- Comparisons are unsigned at CNT_W bits; no counter exceeds TOTAL-1.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [7:0]. Reset 0.
  - Increments (mod 256) in the same cycle frame_start is asserted, so the new value is visible with the first pixel of the frame.
  - Holds when en=0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then en=1 continuously, default params -> x counts 0..799 then 0; hsync low exactly for x=656..751 (96 cycles); active=1 for x<640 while y<480.
- Run 2 full frames -> frame_start pulses exactly every 420000 cycles; vsync low exactly for y=490..491 (1600 cycles); y wraps 524->0.
- en toggled 1/0 alternately -> every output holds on en=0 cycles; strobes never high on en=0 cycles; frame length becomes 840000 clk cycles.
- Small params (H 4/1/1/1, V 3/1/1/1, H_SYNC_POL=1) -> hsync high only at x=5; H_TOTAL=7, V_TOTAL=6; line_start every 7 ticks.
- Assert rst asynchronously mid-hsync at (700,300), between clock edges -> outputs go to reset values before the next edge; after release the first en tick gives x=0, y=0, hsync=1.
- With VGA_TIMING_FRAME_CNT_EN, run 257 frames -> frame_cnt is 1 in frame 1, 255 in frame 255, then wraps to 0 and 1.
